// File: rtl/out_core_port_pkg.sv
// out_core_port_pkg
// Shared definitions for the per-core output port and its result FIFO.
//   - Default burst geometry (reuses the OUT_ARB_* defines when the arbiter
//     side of the build already provides them).
//   - State encodings OUT_PORT_IDLE .. OUT_PORT_READ and the state_e enum.
//   - Default data width / FIFO depth.
//   - cnt_width(): width of an occupancy counter that can hold 0..depth.
// Optional feature macro used by out_core_port: OUT_PORT_READBACK_EN.

`ifndef OUT_ARB_BURST_WIDTH
`define OUT_ARB_BURST_WIDTH 4
`endif
`ifndef OUT_ARB_FIXED_BURST_WRITE
`define OUT_ARB_FIXED_BURST_WRITE 4
`endif
`ifndef OUT_ARB_FIXED_BURST_READ
`define OUT_ARB_FIXED_BURST_READ 4
`endif

`ifndef OUT_PORT_IDLE
`define OUT_PORT_IDLE   3'd0
`define OUT_PORT_REQ_WR 3'd1
`define OUT_PORT_WRITE  3'd2
`define OUT_PORT_REQ_RD 3'd3
`define OUT_PORT_READ   3'd4
`endif

`ifndef OUT_PORT_DATA_WIDTH
`define OUT_PORT_DATA_WIDTH 16
`endif
`ifndef OUT_PORT_FIFO_DEPTH
`define OUT_PORT_FIFO_DEPTH 8
`endif

package out_core_port_pkg;

    localparam int STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE   = `OUT_PORT_IDLE,
        ST_REQ_WR = `OUT_PORT_REQ_WR,
        ST_WRITE  = `OUT_PORT_WRITE,
        ST_REQ_RD = `OUT_PORT_REQ_RD,
        ST_READ   = `OUT_PORT_READ
    } state_e;

    // Occupancy counter width: one extra bit so "full" (== depth) is representable.
    function automatic int cnt_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/out_core_port_sync_fifo.sv
// sync_fifo
// Single-clock FIFO holding PE results until the port can burst them out.
// Ports:
//   w_clock, w_reset_n   clock / asynchronous active-low reset (empties FIFO)
//   w_push, w_din        write request and data; ignored while full
//   w_pop                read request; ignored while empty
//   r_dout               head-of-queue word (combinational, valid when !r_empty)
//   r_full, r_empty      status flags
//   r_count              number of stored words, 0..DEPTH
// A push and a pop in the same cycle are both performed (count unchanged),
// provided the push is not blocked by full.
// DEPTH must be a power of two so the pointers wrap naturally.

module sync_fifo
    import out_core_port_pkg::*;
#(
    parameter int DATA_WIDTH = `OUT_PORT_DATA_WIDTH,
    parameter int DEPTH      = `OUT_PORT_FIFO_DEPTH,
    localparam int PTR_W     = $clog2(DEPTH),
    localparam int CNT_W     = cnt_width(DEPTH)
) (
    input  logic                  w_clock,
    input  logic                  w_reset_n,
    input  logic                  w_push,
    input  logic [DATA_WIDTH-1:0] w_din,
    input  logic                  w_pop,
    output logic [DATA_WIDTH-1:0] r_dout,
    output logic                  r_full,
    output logic                  r_empty,
    output logic [CNT_W-1:0]      r_count
);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic                  do_push;
    logic                  do_pop;

    assign r_full  = (count_q == CNT_W'(DEPTH));
    assign r_empty = (count_q == '0);
    assign r_count = count_q;
    assign r_dout  = mem_q[rd_ptr_q];

    assign do_push = w_push && !r_full;
    assign do_pop  = w_pop && !r_empty;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge w_clock or negedge w_reset_n) begin
        if (!w_reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: emptiness is defined purely by the pointers.
    always_ff @(posedge w_clock) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= w_din;
        end
    end

endmodule

// File: rtl/out_core_port.sv
// out_core_port
// Per-PE-core output port in front of the output-bus arbiter. PE results are
// buffered in a FIFO; once a full write burst is stored the port requests the
// bus, streams the burst on grant, then requests the paired read burst and
// forwards the returned words to the PE. The write/read alternation mirrors
// the arbiter's per-core toggle, so both phases are always traversed.
// Ports:
//   w_clock, w_reset_n      clock / asynchronous active-low reset
//   w_pe_valid, w_pe_data   PE result word in
//   r_pe_ready              FIFO not full (combinational from FIFO count)
//   r_req, w_grant          request to / grant from the arbiter
//   r_bus_wvalid/wdata      registered write beats onto the shared bus
//   w_bus_rvalid/rdata      read beats from main memory
//   r_rd_valid/rd_data      read-back word to the PE, one cycle after rvalid
//   r_short_burst           sticky: grant dropped before a burst completed
//   r_dbg_state             current FSM state (state_e encoding)
// Optional feature: define OUT_PORT_READBACK_EN to forward read beats to the
// PE. Without it read beats are only counted and r_rd_* are tied to zero.
//
// Handshake: the PE side transfers a word on every cycle where
// w_pe_valid && r_pe_ready; words offered while r_pe_ready=0 are dropped.
// The read-back side has no ready: r_rd_valid is a one-cycle pulse the PE
// must take. r_req stays high until the cycle after w_grant is sampled high.

module out_core_port
    import out_core_port_pkg::*;
#(
    parameter int DATA_WIDTH  = `OUT_PORT_DATA_WIDTH,
    parameter int FIFO_DEPTH  = `OUT_PORT_FIFO_DEPTH,
    parameter int BURST_WIDTH = `OUT_ARB_BURST_WIDTH,
    parameter int BURST_WRITE = `OUT_ARB_FIXED_BURST_WRITE,
    parameter int BURST_READ  = `OUT_ARB_FIXED_BURST_READ
) (
    input  logic                  w_clock,
    input  logic                  w_reset_n,
    input  logic                  w_pe_valid,
    input  logic [DATA_WIDTH-1:0] w_pe_data,
    output logic                  r_pe_ready,
    output logic                  r_req,
    input  logic                  w_grant,
    output logic                  r_bus_wvalid,
    output logic [DATA_WIDTH-1:0] r_bus_wdata,
    input  logic                  w_bus_rvalid,
    input  logic [DATA_WIDTH-1:0] w_bus_rdata,
    output logic                  r_rd_valid,
    output logic [DATA_WIDTH-1:0] r_rd_data,
    output logic                  r_short_burst,
    output logic [STATE_W-1:0]    r_dbg_state
);

    localparam int CNT_W = cnt_width(FIFO_DEPTH);
    localparam logic [BURST_WIDTH-1:0] BEATS_WR  = BURST_WIDTH'(BURST_WRITE);
    localparam logic [BURST_WIDTH-1:0] BEATS_RD  = BURST_WIDTH'(BURST_READ);
    localparam logic [CNT_W-1:0]       REQ_LEVEL = CNT_W'(BURST_WRITE);

    state_e                 state_q, state_d;
    logic                   req_q, req_d;
    logic [BURST_WIDTH-1:0] beat_q, beat_d;
    logic                   wvalid_q, wvalid_d;
    logic [DATA_WIDTH-1:0]  wdata_q, wdata_d;
    logic                   short_q, short_d;

    logic                   fifo_pop;
    logic [DATA_WIDTH-1:0]  fifo_dout;
    logic                   fifo_full;
    logic                   fifo_empty;
    logic [CNT_W-1:0]       fifo_count;

`ifdef OUT_PORT_READBACK_EN
    logic                   rd_valid_q, rd_valid_d;
    logic [DATA_WIDTH-1:0]  rd_data_q, rd_data_d;
`endif

    sync_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (FIFO_DEPTH)
    ) u_fifo (
        .w_clock   (w_clock),
        .w_reset_n (w_reset_n),
        .w_push    (w_pe_valid),
        .w_din     (w_pe_data),
        .w_pop     (fifo_pop),
        .r_dout    (fifo_dout),
        .r_full    (fifo_full),
        .r_empty   (fifo_empty),
        .r_count   (fifo_count)
    );

    always_comb begin
        state_d  = state_q;
        req_d    = req_q;
        beat_d   = beat_q;
        wvalid_d = 1'b0;
        wdata_d  = wdata_q;
        short_d  = short_q;
        fifo_pop = 1'b0;
`ifdef OUT_PORT_READBACK_EN
        rd_valid_d = 1'b0;
        rd_data_d  = rd_data_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (fifo_count >= REQ_LEVEL) begin
                    state_d = ST_REQ_WR;
                    req_d   = 1'b1;
                end
            end
            ST_REQ_WR: begin
                if (w_grant) begin
                    state_d = ST_WRITE;
                    req_d   = 1'b0;
                    beat_d  = '0;
                end
            end
            ST_WRITE: begin
                if (!w_grant) begin
                    // Unsent words stay queued; they go out in a later burst.
                    state_d = ST_REQ_RD;
                    req_d   = 1'b1;
                    if (beat_q < BEATS_WR) begin
                        short_d = 1'b1;
                    end
                end else if ((beat_q < BEATS_WR) && !fifo_empty) begin
                    fifo_pop = 1'b1;
                    wvalid_d = 1'b1;
                    wdata_d  = fifo_dout;
                    beat_d   = beat_q + BURST_WIDTH'(1);
                end
            end
            ST_REQ_RD: begin
                if (w_grant) begin
                    state_d = ST_READ;
                    req_d   = 1'b0;
                    beat_d  = '0;
                end
            end
            ST_READ: begin
                // Grant loss takes priority over a coincident read beat.
                if (!w_grant) begin
                    state_d = ST_IDLE;
                    if (beat_q < BEATS_RD) begin
                        short_d = 1'b1;
                    end
                end else if (w_bus_rvalid && (beat_q < BEATS_RD)) begin
                    beat_d = beat_q + BURST_WIDTH'(1);
`ifdef OUT_PORT_READBACK_EN
                    rd_valid_d = 1'b1;
                    rd_data_d  = w_bus_rdata;
`endif
                end
            end
            default: begin
                state_d = ST_IDLE;
                req_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge w_clock or negedge w_reset_n) begin
        if (!w_reset_n) begin
            state_q  <= ST_IDLE;
            req_q    <= 1'b0;
            beat_q   <= '0;
            wvalid_q <= 1'b0;
            wdata_q  <= '0;
            short_q  <= 1'b0;
`ifdef OUT_PORT_READBACK_EN
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
`endif
        end else begin
            state_q  <= state_d;
            req_q    <= req_d;
            beat_q   <= beat_d;
            wvalid_q <= wvalid_d;
            wdata_q  <= wdata_d;
            short_q  <= short_d;
`ifdef OUT_PORT_READBACK_EN
            rd_valid_q <= rd_valid_d;
            rd_data_q  <= rd_data_d;
`endif
        end
    end

    assign r_pe_ready    = !fifo_full;
    assign r_req         = req_q;
    assign r_bus_wvalid  = wvalid_q;
    assign r_bus_wdata   = wdata_q;
    assign r_short_burst = short_q;
    assign r_dbg_state   = state_q;

`ifdef OUT_PORT_READBACK_EN
    assign r_rd_valid = rd_valid_q;
    assign r_rd_data  = rd_data_q;
`else
    // Read data is discarded in this build; only the beat count matters.
    logic unused_rdata;
    assign unused_rdata = ^w_bus_rdata;
    assign r_rd_valid   = 1'b0;
    assign r_rd_data    = '0;
`endif

endmodule

// File: tb/tb_out_core_port.sv
// Testbench for out_core_port (DATA_WIDTH=16, FIFO_DEPTH=8, bursts of 4).
// The bench plays both the PE and the arbiter/memory. A queue model of the
// FIFO predicts which words each write burst must carry and which read words
// come back; a separate monitor compares every DUT beat against the queues.

module tb_out_core_port;

  localparam int DW    = 16;
  localparam int DEPTH = 8;
  localparam int BW    = 4;
  localparam int BR    = 4;

`ifdef OUT_PORT_READBACK_EN
  localparam bit RB_EN = 1'b1;
`else
  localparam bit RB_EN = 1'b0;
`endif

  // clock / reset
  logic w_clock = 1'b0;
  logic w_reset_n = 1'b0;
  always #5 w_clock = ~w_clock;

  logic          w_pe_valid;
  logic [DW-1:0] w_pe_data;
  logic          r_pe_ready;
  logic          r_req;
  logic          w_grant;
  logic          r_bus_wvalid;
  logic [DW-1:0] r_bus_wdata;
  logic          w_bus_rvalid;
  logic [DW-1:0] w_bus_rdata;
  logic          r_rd_valid;
  logic [DW-1:0] r_rd_data;
  logic          r_short_burst;
  logic [2:0]    r_dbg_state;

  out_core_port #(
    .DATA_WIDTH  (DW),
    .FIFO_DEPTH  (DEPTH),
    .BURST_WIDTH (4),
    .BURST_WRITE (BW),
    .BURST_READ  (BR)
  ) dut (
    .w_clock       (w_clock),
    .w_reset_n     (w_reset_n),
    .w_pe_valid    (w_pe_valid),
    .w_pe_data     (w_pe_data),
    .r_pe_ready    (r_pe_ready),
    .r_req         (r_req),
    .w_grant       (w_grant),
    .r_bus_wvalid  (r_bus_wvalid),
    .r_bus_wdata   (r_bus_wdata),
    .w_bus_rvalid  (w_bus_rvalid),
    .w_bus_rdata   (w_bus_rdata),
    .r_rd_valid    (r_rd_valid),
    .r_rd_data     (r_rd_data),
    .r_short_burst (r_short_burst),
    .r_dbg_state   (r_dbg_state)
  );

  // scoreboard state
  int n_vec = 0;
  int n_err = 0;
  logic [DW-1:0] model_q[$];
  logic [DW-1:0] exp_wr_q[$];
  logic [DW-1:0] exp_rd_q[$];
  bit model_short = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // monitor: every presented beat must match the head of its expected queue
  always @(negedge w_clock) begin
    if (w_reset_n) begin
      if (r_bus_wvalid) begin
        if (exp_wr_q.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL wdata_extra: beat 0x%0h, expected no beat at %0t", r_bus_wdata, $time);
        end else begin
          check("wdata", r_bus_wdata, exp_wr_q.pop_front());
        end
      end
      if (r_rd_valid) begin
        if (exp_rd_q.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL rd_extra: word 0x%0h, expected no word at %0t", r_rd_data, $time);
        end else begin
          check("rd_data", r_rd_data, exp_rd_q.pop_front());
        end
      end
    end
  end

  // driver: one clock cycle, called and returning at a falling edge
  task automatic cycle(input bit pv, input logic [DW-1:0] pd, input bit gnt,
                       input bit pop_exp, input bit rv, input logic [DW-1:0] rd,
                       input bit fwd);
    bit ready_exp;
    w_pe_valid   = pv;
    w_pe_data    = pd;
    w_grant      = gnt;
    w_bus_rvalid = rv;
    w_bus_rdata  = rd;
    ready_exp = (model_q.size() < DEPTH);
    if (pv) check("pe_ready", r_pe_ready, ready_exp);
    @(posedge w_clock);
    if (pop_exp && model_q.size() > 0) exp_wr_q.push_back(model_q.pop_front());
    if (pv && ready_exp) model_q.push_back(pd);
    if (fwd && RB_EN) exp_rd_q.push_back(rd);
    @(negedge w_clock);
    w_pe_valid   = 1'b0;
    w_bus_rvalid = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, '0, 1'b0, 1'b0, 1'b0, '0, 1'b0);
  endtask

  task automatic push(input logic [DW-1:0] d);
    cycle(1'b1, d, 1'b0, 1'b0, 1'b0, '0, 1'b0);
  endtask

  // fill the FIFO to a full burst, then expect the write request
  task automatic fill();
    bit pushed = 1'b0;
    while (model_q.size() < BW) begin
      push(DW'($urandom));
      pushed = 1'b1;
    end
    if (pushed) check("req_before_level", r_req, 1'b0);
    idle(1);
    check("req_rise", r_req, 1'b1);
  endtask

  // write grant held for g sampled edges; beats fall on edges 1..BW
  task automatic burst_wr(input int g, input int push_pct);
    check("req_wr_pending", r_req, 1'b1);
    for (int i = 0; i < g; i++) begin
      bit pv;
      pv = ($urandom_range(99) < push_pct);
      cycle(pv, DW'($urandom), 1'b1, (i >= 1 && i <= BW), 1'b0, '0, 1'b0);
      if (i == 0) check("req_clear_wr", r_req, 1'b0);
    end
    cycle(($urandom_range(99) < push_pct), DW'($urandom), 1'b0, 1'b0, 1'b0, '0, 1'b0);
    if (g - 1 < BW) model_short = 1'b1;
    check("req_rd", r_req, 1'b1);
    check("state_req_rd", r_dbg_state, 3'd3);
    check("short_after_wr", r_short_burst, model_short);
  endtask

  // read grant held for g sampled edges; rvalid offered on edges 1..g-1
  task automatic burst_rd(input int g, input int rv_pct, input bit directed);
    int fwd = 0;
    for (int i = 0; i < g; i++) begin
      bit rv;
      bit f;
      logic [DW-1:0] rd;
      rv = (i >= 1) && (directed ? (i <= BR) : ($urandom_range(99) < rv_pct));
      rd = directed ? DW'(16'hA000 + i - 1) : DW'($urandom);
      f  = rv && (fwd < BR);
      cycle(directed ? 1'b0 : ($urandom_range(1) == 1), DW'($urandom), 1'b1, 1'b0, rv, rd, f);
      if (i == 0) check("req_clear_rd", r_req, 1'b0);
      if (f) fwd++;
    end
    cycle(1'b0, '0, 1'b0, 1'b0, 1'b0, '0, 1'b0);
    if (fwd < BR) model_short = 1'b1;
    check("state_idle", r_dbg_state, 3'd0);
    check("short_after_rd", r_short_burst, model_short);
  endtask

  task automatic check_reset_outputs();
    check("rst_req", r_req, 1'b0);
    check("rst_wvalid", r_bus_wvalid, 1'b0);
    check("rst_wdata", r_bus_wdata, '0);
    check("rst_rd_valid", r_rd_valid, 1'b0);
    check("rst_rd_data", r_rd_data, '0);
    check("rst_short", r_short_burst, 1'b0);
    check("rst_pe_ready", r_pe_ready, 1'b1);
    check("rst_state", r_dbg_state, 3'd0);
  endtask

  // watchdog
  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    w_pe_valid = 1'b0; w_pe_data = '0; w_grant = 1'b0;
    w_bus_rvalid = 1'b0; w_bus_rdata = '0;
    w_reset_n = 1'b0;
    repeat (3) @(negedge w_clock);
    check_reset_outputs();
    w_reset_n = 1'b1;

    // request threshold
    push(16'h0011); check("req_at_1", r_req, 1'b0);
    push(16'h0022); check("req_at_2", r_req, 1'b0);
    push(16'h0033); check("req_at_3", r_req, 1'b0);
    push(16'h0044); check("req_at_4_same", r_req, 1'b0);
    idle(1);        check("req_at_4_next", r_req, 1'b1);

    // full write burst, then directed read of 0xA000..0xA003
    burst_wr(6, 0);
    burst_rd(6, 0, 1'b1);
    idle(3);
    check("req_empty_fifo", r_req, 1'b0);

    // overfill: ninth word dropped, then burst with pushes every cycle
    for (int k = 0; k < 9; k++) push(DW'(16'h0100 + k));
    check("ready_full", r_pe_ready, 1'b0);
    burst_wr(6, 100);
    burst_rd(6, 100, 1'b0);

    // short write: grant falls after 2 beats
    fill();
    burst_wr(3, 0);
    check("short_sticky_set", r_short_burst, 1'b1);
    burst_rd(6, 100, 1'b0);
    check("short_sticky_hold", r_short_burst, 1'b1);

    // reset in the middle of a write burst
    fill();
    cycle(1'b0, '0, 1'b1, 1'b0, 1'b0, '0, 1'b0);
    cycle(1'b0, '0, 1'b1, 1'b1, 1'b0, '0, 1'b0);
    #2;
    w_reset_n = 1'b0;
    w_grant   = 1'b0;
    #1;
    check_reset_outputs();
    model_q.delete();
    exp_wr_q.delete();
    exp_rd_q.delete();
    model_short = 1'b0;
    repeat (2) @(negedge w_clock);
    w_reset_n = 1'b1;
    idle(3);
    check("req_after_reset", r_req, 1'b0);
    check("ready_after_reset", r_pe_ready, 1'b1);

    // randomized phases
    for (int it = 0; it < 30; it++) begin
      fill();
      burst_wr($urandom_range(1, 8), $urandom_range(0, 100));
      burst_rd($urandom_range(1, 8), $urandom_range(0, 100), 1'b0);
    end

    idle(3);
    check("wr_queue_drained", exp_wr_q.size(), 0);
    check("rd_queue_drained", exp_rd_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
